enc422_pending: RTL and testbench

Sequential 4-to-2 priority encoder, the inverse of the team's 2-to-4 decoder. It latches one-hot or multi-hot request pulses on `in[3:0]` into a pending register and emits them one at a time as 2-bit codes on `out`. Each code is held under a valid/ack handshake. It sits upstream of the decoder, so a decoded `out` reproduces the single request line being served.

---
 rtl/enc422_pending.sv | 83 ++++++++
 tb/tb_enc422_pending.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/enc422_pending.sv
// rtl/enc422_pending.sv - sequential 4-to-2 priority encoder with pending requests and valid/ack hold
module enc422_pending #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  input  logic       enable,
  input  logic       ack,
  output logic [1:0] out,
  output logic       valid,
  output logic [3:0] pend,
  output logic       drop
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state, state_n;
  logic [1:0] out_n;
  logic [3:0] pend_n;
  logic       drop_n;
  logic [3:0] req;
  logic [3:0] cand;
  logic [1:0] pick;
  logic       found;
  logic       load;

  assign req   = enable ? in : 4'b0000;
  assign cand  = pend | req;
  assign load  = (state == IDLE) || ack;
  assign valid = (state == HOLD);

  // First set bit of cand in the configured priority order.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (LSB_FIRST) begin
        if (!found && cand[i]) begin
          pick  = 2'(i);
          found = 1'b1;
        end
      end else begin
        if (!found && cand[3-i]) begin
          pick  = 2'(3 - i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    out_n   = out;
    pend_n  = cand;
    drop_n  = |(req & pend);
    if (load) begin
      if (found) begin
        state_n = HOLD;
        out_n   = pick;
        pend_n  = cand & ~(4'b0001 << pick);
      end else begin
        state_n = IDLE;
        pend_n  = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out   <= 2'd0;
      pend  <= 4'b0000;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      out   <= out_n;
      pend  <= pend_n;
      drop  <= drop_n;
    end
  end

endmodule

// File: tb/tb_enc422_pending.sv
// tb/tb_enc422_pending.sv - randomized and directed bench for enc422_pending, both priority orders
module tb_enc422_pending;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in;
  logic       enable;
  logic       ack;
  logic [1:0] d_out   [2];
  logic       d_valid [2];
  logic [3:0] d_pend  [2];
  logic       d_drop  [2];

  logic [3:0] m_pend  [2];
  logic [1:0] m_out   [2];
  logic       m_valid [2];
  logic       m_drop  [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  enc422_pending #(.LSB_FIRST(1'b1)) u_dut_lsb (
    .clk(clk), .rst(rst), .in(in), .enable(enable), .ack(ack),
    .out(d_out[0]), .valid(d_valid[0]), .pend(d_pend[0]), .drop(d_drop[0])
  );

  enc422_pending #(.LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .rst(rst), .in(in), .enable(enable), .ack(ack),
    .out(d_out[1]), .valid(d_valid[1]), .pend(d_pend[1]), .drop(d_drop[1])
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Index of the request that wins: k=0 scans 0..3, k=1 scans 3..0.
  function automatic int winner(input logic [3:0] c, input int k);
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (k == 0) ? i : 3 - i;
      if (c[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input int k);
    logic [3:0] r, c;
    int p;
    if (rst) begin
      m_pend[k] = 4'b0; m_out[k] = 2'd0; m_valid[k] = 1'b0; m_drop[k] = 1'b0;
      return;
    end
    r = enable ? in : 4'b0;
    c = m_pend[k] | r;
    m_drop[k] = (r & m_pend[k]) != 4'b0;
    if (!m_valid[k] || ack) begin
      p = winner(c, k);
      if (p >= 0) begin
        m_out[k]   = 2'(p);
        m_valid[k] = 1'b1;
        c[p]       = 1'b0;
        m_pend[k]  = c;
      end else begin
        m_valid[k] = 1'b0;
        m_pend[k]  = 4'b0;
      end
    end else begin
      m_pend[k] = c;
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare on the falling edge.
  task automatic cyc(input logic r, input logic [3:0] i, input logic e, input logic a);
    rst = r; in = i; enable = e; ack = a;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("out%0d", k),   {2'b0, d_out[k]},   {2'b0, m_out[k]});
      chk($sformatf("valid%0d", k), {3'b0, d_valid[k]}, {3'b0, m_valid[k]});
      chk($sformatf("pend%0d", k),  d_pend[k],          m_pend[k]);
      chk($sformatf("drop%0d", k),  {3'b0, d_drop[k]},  {3'b0, m_drop[k]});
    end
  endtask

  task automatic check_seq(input int k, input logic [3:0] i, input logic e, input logic [1:0] s[$]);
    logic [1:0] exp[$];
    for (int n = 0; n < 4; n++) begin
      int j;
      j = (k == 0) ? n : 3 - n;
      if (e && i[j]) exp.push_back(2'(j));
    end
    chk($sformatf("sweep%0d_len_%h_%b", k, i, e), 4'(s.size()), 4'(exp.size()));
    for (int n = 0; n < s.size() && n < exp.size(); n++) begin
      chk($sformatf("sweep%0d_code_%h", k, i), {2'b0, s[n]}, {2'b0, exp[n]});
      chk($sformatf("sweep%0d_decode_%h", k, i), 4'b0001 << s[n], (4'b0001 << s[n]) & i);
    end
  endtask

  initial begin
    logic [1:0] s0[$];
    logic [1:0] s1[$];
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 4'b0; m_out[k] = 2'd0; m_valid[k] = 1'b0; m_drop[k] = 1'b0;
    end
    rst = 1'b1; in = 4'b0; enable = 1'b0; ack = 1'b0;
    @(negedge clk);

    cyc(1, 4'b0, 0, 0);
    chk("reset_pend", d_pend[0], 4'b0000);
    chk("reset_valid", {3'b0, d_valid[0]}, 4'b0000);

    // Reset in the middle of a hold.
    cyc(0, 4'b0100, 1, 0);
    chk("hold_out", {2'b0, d_out[0]}, 4'd2);
    cyc(1, 4'b0110, 1, 0);
    chk("rst_hold_valid", {3'b0, d_valid[0]}, 4'd0);
    chk("rst_hold_out", {2'b0, d_out[0]}, 4'd0);
    chk("rst_hold_pend", d_pend[0], 4'b0000);

    // Priority order, ack held.
    cyc(0, 4'b1010, 1, 1);
    chk("prio_lsb_1", {2'b0, d_out[0]}, 4'd1);
    chk("prio_msb_1", {2'b0, d_out[1]}, 4'd3);
    cyc(0, 4'b0, 1, 1);
    chk("prio_lsb_2", {2'b0, d_out[0]}, 4'd3);
    chk("prio_msb_2", {2'b0, d_out[1]}, 4'd1);
    cyc(0, 4'b0, 1, 1);
    chk("prio_empty", {3'b0, d_valid[0]}, 4'd0);

    // Stall, then a single ack.
    cyc(1, 4'b0, 0, 0);
    cyc(0, 4'b0011, 1, 0);
    cyc(0, 4'b0, 1, 0);
    cyc(0, 4'b0, 1, 0);
    chk("stall_out", {2'b0, d_out[0]}, 4'd0);
    chk("stall_pend", d_pend[0], 4'b0010);
    cyc(0, 4'b0, 1, 1);
    chk("stall_ack_out", {2'b0, d_out[0]}, 4'd1);
    chk("stall_ack_pend", d_pend[0], 4'b0000);

    // Coalesce into an already-pending bit.
    cyc(1, 4'b0, 0, 0);
    cyc(0, 4'b0110, 1, 0);
    cyc(0, 4'b0100, 1, 0);
    chk("coal_pend", d_pend[0], 4'b0100);
    chk("coal_drop", {3'b0, d_drop[0]}, 4'd1);
    cyc(0, 4'b0, 1, 1);
    chk("coal_next", {2'b0, d_out[0]}, 4'd2);
    cyc(0, 4'b0, 1, 1);
    chk("coal_done", {3'b0, d_valid[0]}, 4'd0);

    // Enable gating, then drain a preloaded bit with enable low.
    cyc(1, 4'b0, 0, 0);
    cyc(0, 4'b1111, 0, 0);
    chk("gate_valid", {3'b0, d_valid[0]}, 4'd0);
    chk("gate_pend", d_pend[0], 4'b0000);
    cyc(0, 4'b1001, 1, 0);
    chk("preload_pend", d_pend[0], 4'b1000);
    cyc(0, 4'b1111, 0, 1);
    chk("gate_drain", {2'b0, d_out[0]}, 4'd3);

    // Exhaustive sweep of {in, enable}.
    for (int v = 0; v < 32; v++) begin
      logic [4:0] vv;
      vv = 5'(v);
      s0.delete();
      s1.delete();
      cyc(1, 4'b0, 0, 1);
      cyc(0, vv[4:1], vv[0], 1);
      for (int n = 0; n < 5; n++) begin
        if (d_valid[0]) s0.push_back(d_out[0]);
        if (d_valid[1]) s1.push_back(d_out[1]);
        cyc(0, 4'b0, 1, 1);
      end
      check_seq(0, vv[4:1], vv[0], s0);
      check_seq(1, vv[4:1], vv[0], s1);
    end

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 40) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
